// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, round functions and the responder FSM encoding.
package sha256_pkg;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  // Ascending range so that the first literal is K[0].
  localparam logic [0:63][31:0] SHA256_K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ROUNDS = 3'd2,
    ST_ADD    = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_hash_responder_if.sv
// Hash-port request/response bundle between an initiator (master) and the responder (slave).
interface sha256_hash_responder_if;
  logic          hash_start;
  logic [1023:0] hash_data_in;
  logic          message_length;
  logic          store_intermediate;
  logic          continue_intermediate;
  logic          hash_done;
  logic [255:0]  hash_data_out;
  logic          busy;

  modport master (
    output hash_start, hash_data_in, message_length, store_intermediate, continue_intermediate,
    input  hash_done, hash_data_out, busy
  );

  modport slave (
    input  hash_start, hash_data_in, message_length, store_intermediate, continue_intermediate,
    output hash_done, hash_data_out, busy
  );
endinterface

// File: rtl/sha256_round_core.sv
// SHA-256 compression datapath: working variables a..h and a 16-word rolling message schedule.
module sha256_round_core
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  logic [255:0] state_in,
  input  logic [511:0] block_in,
  input  logic [5:0]   round_idx,
  output logic [255:0] vars_out
);

  logic [31:0] r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
  logic [31:0] r_w [16];
  logic [31:0] w_t1, w_t2, w_wnew;

  assign w_t1   = r_h + big_sigma1(r_e) + ch(r_e, r_f, r_g) + SHA256_K[round_idx] + r_w[0];
  assign w_t2   = big_sigma0(r_a) + maj(r_a, r_b, r_c);
  // r_w[0] always holds W[t]; the word pushed in is W[t+16].
  assign w_wnew = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];

  assign vars_out = {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
    end else if (load) begin
      {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= state_in;
      for (int i = 0; i < 16; i++) r_w[i] <= block_in[511-32*i -: 32];
    end else if (step) begin
      r_a <= w_t1 + w_t2;
      r_b <= r_a;
      r_c <= r_b;
      r_d <= r_c;
      r_e <= r_d + w_t1;
      r_f <= r_e;
      r_g <= r_f;
      r_h <= r_g;
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
      r_w[15] <= w_wnew;
    end
  end

endmodule

// File: rtl/sha256_hash_responder.sv
// Hash-port responder: 1 or 2 pre-padded blocks, optional midstate store/reuse, 256-bit digest out.
// state | meaning: IDLE wait start; LOAD seed core; ROUNDS 64 steps; ADD feed-forward; DONE digest pulse
module sha256_hash_responder
  import sha256_pkg::*;
#(
  parameter int KEY_LEN = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  sha256_hash_responder_if.slave    bus
);

  state_t              r_state, w_next;
  logic [1023:0]       r_data;
  logic                r_len, r_store, r_blk;
  logic [5:0]          r_round;
  logic [255:0]        r_h, r_mid;
  logic                r_mid_valid;
  logic [KEY_LEN-1:0]  r_digest;
  logic                w_accept, w_load, w_step, w_done, w_last;
  logic [511:0]        w_block;
  logic [255:0]        w_vars, w_h_sum;

  assign w_accept = bus.hash_start && (r_state == ST_IDLE);
  assign w_block  = r_blk ? r_data[511:0] : r_data[1023:512];
  assign w_last   = r_blk || !r_len;

  always_comb begin
    w_h_sum = '0;
    for (int i = 0; i < 8; i++) w_h_sum[32*i +: 32] = r_h[32*i +: 32] + w_vars[32*i +: 32];
  end

  sha256_round_core u_core (
    .clk       (clk),
    .reset     (reset),
    .load      (w_load),
    .step      (w_step),
    .state_in  (r_h),
    .block_in  (w_block),
    .round_idx (r_round),
    .vars_out  (w_vars)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_LOAD;
      ST_LOAD:   begin w_load = 1'b1; w_next = ST_ROUNDS; end
      ST_ROUNDS: begin w_step = 1'b1; if (r_round == 6'd63) w_next = ST_ADD; end
      ST_ADD:    w_next = w_last ? ST_DONE : ST_LOAD;
      ST_DONE:   begin w_done = 1'b1; w_next = ST_IDLE; end
      default:   w_next = ST_IDLE;
    endcase
  end

  // Round counter wraps 63->0 by itself, so it is already zero for the next block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data      <= '0;
      r_len       <= 1'b0;
      r_store     <= 1'b0;
      r_blk       <= 1'b0;
      r_round     <= '0;
      r_h         <= '0;
      r_mid       <= '0;
      r_mid_valid <= 1'b0;
      r_digest    <= '0;
    end else begin
      if (w_accept) begin
        r_data  <= bus.hash_data_in;
        r_len   <= bus.message_length;
        r_store <= bus.store_intermediate;
        r_blk   <= 1'b0;
        r_h     <= (bus.continue_intermediate && !bus.store_intermediate && r_mid_valid)
                   ? r_mid : SHA256_IV;
      end
      if (w_step) r_round <= r_round + 6'd1;
      if (r_state == ST_ADD) begin
        r_h <= w_h_sum;
        if (!r_blk && r_store) begin
          r_mid       <= w_h_sum;
          r_mid_valid <= 1'b1;
        end
        if (w_last) r_digest <= w_h_sum;
        else        r_blk    <= 1'b1;
      end
    end
  end

  assign bus.hash_done     = w_done;
  assign bus.hash_data_out = r_digest;
  assign bus.busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sha256_hash_responder.sv
// Scenario bench for sha256_hash_responder: known-answer digests, latency, midstate and abort behaviour.
module tb_sha256_hash_responder;

  typedef struct {
    logic [255:0] dig;
    int           due;
  } exp_t;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] M2_B0   = 512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
  localparam logic [511:0] M2_B1   = {480'h0, 32'h000001c0};
  localparam logic [255:0] M2_DIG  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   t_start;
  exp_t sb[$];

  sha256_hash_responder_if bus();

  sha256_hash_responder #(.KEY_LEN(256)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic start_req(input logic [1023:0] d, input logic len, input logic st, input logic ct,
                           input logic [255:0] dig);
    exp_t e;
    @(negedge clk);
    bus.hash_data_in          = d;
    bus.message_length        = len;
    bus.store_intermediate    = st;
    bus.continue_intermediate = ct;
    bus.hash_start            = 1'b1;
    t_start = cyc;
    e.dig = dig;
    e.due = cyc + (len ? 133 : 67);
    sb.push_back(e);
    @(negedge clk);
    bus.hash_start            = 1'b0;
    bus.hash_data_in          = '1;
    bus.message_length        = 1'b0;
    bus.store_intermediate    = 1'b0;
    bus.continue_intermediate = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output int at, output logic [255:0] dig);
    seen = 1'b0;
    at   = -1;
    dig  = '0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.hash_done === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
        dig  = bus.hash_data_out;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.hash_done !== 1'b0) $display("FAIL rst_done got %b want 0", bus.hash_done); else n_pass++;
    n_checks++; if (bus.hash_data_out !== 256'h0) $display("FAIL rst_dout got %h want 0", bus.hash_data_out); else n_pass++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_abc();
    bit seen; int at; logic [255:0] dig; exp_t e;
    start_req({ABC_BLK, M2_B1}, 1'b0, 1'b0, 1'b0, ABC_DIG);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL abc_busy got %b want 1", bus.busy); else n_pass++;
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (seen !== 1'b1) $display("FAIL abc_seen got %b want 1", seen); else n_pass++;
    n_checks++; if (at !== e.due) $display("FAIL abc_lat got %0d want %0d", at, e.due); else n_pass++;
    n_checks++; if (dig !== e.dig) $display("FAIL abc_dig got %h want %h", dig, e.dig); else n_pass++;
    @(negedge clk);
    n_checks++; if (bus.hash_done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL abc_after got done=%b busy=%b want 0 0", bus.hash_done, bus.busy); else n_pass++;
    n_checks++; if (bus.hash_data_out !== ABC_DIG) $display("FAIL abc_hold got %h want %h", bus.hash_data_out, ABC_DIG); else n_pass++;
  endtask

  task automatic test_continue_no_store();
    bit seen; int at; logic [255:0] dig; exp_t e;
    start_req({ABC_BLK, M2_B0}, 1'b0, 1'b0, 1'b1, ABC_DIG);
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (at !== e.due) $display("FAIL cont_iv_lat got %0d want %0d", at, e.due); else n_pass++;
    n_checks++; if (dig !== e.dig) $display("FAIL cont_iv_dig got %h want %h", dig, e.dig); else n_pass++;
  endtask

  task automatic test_two_block();
    bit seen; int at; logic [255:0] dig; exp_t e;
    start_req({M2_B0, M2_B1}, 1'b1, 1'b0, 1'b0, M2_DIG);
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (at !== e.due) $display("FAIL two_lat got %0d want %0d", at, e.due); else n_pass++;
    n_checks++; if (dig !== e.dig) $display("FAIL two_dig got %h want %h", dig, e.dig); else n_pass++;
  endtask

  task automatic test_midstate();
    bit seen; int at; logic [255:0] dig; exp_t e;
    start_req({M2_B0, M2_B1}, 1'b1, 1'b1, 1'b0, M2_DIG);
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (dig !== e.dig) $display("FAIL mid_store_dig got %h want %h", dig, e.dig); else n_pass++;
    start_req({M2_B1, ABC_BLK}, 1'b0, 1'b0, 1'b1, M2_DIG);
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (at !== e.due) $display("FAIL mid_cont_lat got %0d want %0d", at, e.due); else n_pass++;
    n_checks++; if (dig !== e.dig) $display("FAIL mid_cont_dig got %h want %h", dig, e.dig); else n_pass++;
  endtask

  task automatic test_both_flags();
    bit seen; int at; logic [255:0] dig; exp_t e;
    start_req({ABC_BLK, M2_B1}, 1'b0, 1'b1, 1'b0, ABC_DIG);
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (dig !== e.dig) $display("FAIL both_pre_dig got %h want %h", dig, e.dig); else n_pass++;
    // Midstate now holds the abc state; both flags must still start from the IV.
    start_req({M2_B0, M2_B1}, 1'b1, 1'b1, 1'b1, M2_DIG);
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (at !== e.due) $display("FAIL both_lat got %0d want %0d", at, e.due); else n_pass++;
    n_checks++; if (dig !== e.dig) $display("FAIL both_dig got %h want %h", dig, e.dig); else n_pass++;
    start_req({M2_B1, M2_B0}, 1'b0, 1'b0, 1'b1, M2_DIG);
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (dig !== e.dig) $display("FAIL both_cont_dig got %h want %h", dig, e.dig); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit seen; int at; logic [255:0] dig; exp_t e; int n_done; int t0;
    n_done = 0;
    at = -1;
    dig = '0;
    start_req({ABC_BLK, M2_B1}, 1'b0, 1'b0, 1'b0, ABC_DIG);
    t0 = t_start;
    while (cyc < t0 + 67) begin
      @(negedge clk);
      bus.hash_start = (cyc == t0 + 10) || (cyc == t0 + 66) || (cyc == t0 + 67);
      bus.hash_data_in = {M2_B0, M2_B0};
      bus.message_length = 1'b1;
      if (bus.hash_done === 1'b1) begin
        n_done++;
        at  = cyc;
        dig = bus.hash_data_out;
      end
    end
    e = sb.pop_front();
    n_checks++; if (n_done !== 1) $display("FAIL b2b_ndone got %0d want 1", n_done); else n_pass++;
    n_checks++; if (at !== e.due) $display("FAIL b2b_lat got %0d want %0d", at, e.due); else n_pass++;
    n_checks++; if (dig !== e.dig) $display("FAIL b2b_dig got %h want %h", dig, e.dig); else n_pass++;
    start_req({M2_B0, M2_B1}, 1'b1, 1'b0, 1'b0, M2_DIG);
    n_checks++; if (t_start !== t0 + 68) $display("FAIL b2b_restart got %0d want %0d", t_start, t0 + 68); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy got %b want 1", bus.busy); else n_pass++;
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (at !== e.due) $display("FAIL b2b2_lat got %0d want %0d", at, e.due); else n_pass++;
    n_checks++; if (dig !== e.dig) $display("FAIL b2b2_dig got %h want %h", dig, e.dig); else n_pass++;
  endtask

  task automatic test_reset_abort();
    bit seen; int at; logic [255:0] dig; exp_t e; int n_done;
    start_req({M2_B0, M2_B1}, 1'b1, 1'b1, 1'b0, M2_DIG);
    void'(sb.pop_back());
    while (cyc < t_start + 40) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL abort_busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.hash_data_out !== 256'h0) $display("FAIL abort_dout got %h want 0", bus.hash_data_out); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (bus.hash_done === 1'b1) n_done++;
    end
    n_checks++; if (n_done !== 0) $display("FAIL abort_nodone got %0d want 0", n_done); else n_pass++;
    // A midstate would only exist from the aborted request's block0, which never reached ADD.
    start_req({ABC_BLK, M2_B1}, 1'b0, 1'b0, 1'b1, ABC_DIG);
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (at !== e.due) $display("FAIL abort_cont_lat got %0d want %0d", at, e.due); else n_pass++;
    n_checks++; if (dig !== e.dig) $display("FAIL abort_cont_dig got %h want %h", dig, e.dig); else n_pass++;
  endtask

  task automatic test_reset_clears_midstate();
    bit seen; int at; logic [255:0] dig; exp_t e;
    start_req({M2_B0, M2_B1}, 1'b1, 1'b1, 1'b0, M2_DIG);
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (dig !== e.dig) $display("FAIL clr_store_dig got %h want %h", dig, e.dig); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start_req({ABC_BLK, M2_B1}, 1'b0, 1'b0, 1'b1, ABC_DIG);
    wait_done(seen, at, dig);
    e = sb.pop_front();
    n_checks++; if (dig !== e.dig) $display("FAIL clr_cont_dig got %h want %h", dig, e.dig); else n_pass++;
  endtask

  initial begin
    bus.hash_start            = 1'b0;
    bus.hash_data_in          = '0;
    bus.message_length        = 1'b0;
    bus.store_intermediate    = 1'b0;
    bus.continue_intermediate = 1'b0;
    test_reset();
    test_abc();
    test_continue_no_store();
    test_two_block();
    test_midstate();
    test_both_flags();
    test_back_to_back();
    test_reset_abort();
    test_reset_clears_midstate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
